// File: rtl/controlo_barreira_if.sv
// Signal bundle between the car-park request/sensor side and the barrier controller.
// The requester side (master) drives the requests and the sensor. The controller side (slave) drives the barrier and status.
interface controlo_barreira_if;
    logic       pedido_entrada;
    logic       pedido_saida;
    logic       sensor_carro;
    logic       barreira;
    logic       concede_entrada;
    logic       concede_saida;
    logic [6:0] tempo;
    logic [6:0] ocupados;
    logic       cheio;
    logic       aviso;

    modport master (
        output pedido_entrada, pedido_saida, sensor_carro,
        input  barreira, concede_entrada, concede_saida, tempo, ocupados, cheio, aviso
    );

    modport slave (
        input  pedido_entrada, pedido_saida, sensor_carro,
        output barreira, concede_entrada, concede_saida, tempo, ocupados, cheio, aviso
    );
endinterface

// File: rtl/controlo_barreira.sv
// Car-park barrier sequencer: arbitrates entry/exit requests, times the open interval, tracks occupancy.
// Optional warning lamp enabled by defining BARREIRA_AVISO_EN.
module controlo_barreira #(
    parameter int CICLOS_SEG   = 50000000,
    parameter int TEMPO_ABERTA = 6,
    parameter int LUGARES      = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    controlo_barreira_if.slave   bus
);
    typedef enum logic {FECHADA, ABERTA} estado_t;

    localparam int               PW         = $clog2(CICLOS_SEG);
    localparam logic [PW-1:0]    PRESC_MAX  = PW'(CICLOS_SEG - 1);
    localparam logic [6:0]       LUGARES_7  = 7'(LUGARES);
    localparam logic [6:0]       TEMPO_AB_7 = 7'(TEMPO_ABERTA);

    estado_t       estado_q, estado_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    tempo_q, tempo_d;
    logic [6:0]    ocupados_q, ocupados_d;
    logic          barreira_q, barreira_d;
    logic          conc_e_q, conc_e_d;
    logic          conc_s_q, conc_s_d;
    logic          ultimo_saida_q, ultimo_saida_d;
    logic          elig_e, elig_s;
    logic [6:0]    tempo_inc;

    assign elig_e    = bus.pedido_entrada && (ocupados_q < LUGARES_7);
    assign elig_s    = bus.pedido_saida && (ocupados_q != 7'd0);
    assign tempo_inc = (tempo_q == 7'd127) ? tempo_q : tempo_q + 7'd1;

    always_comb begin
        estado_d       = estado_q;
        presc_d        = presc_q;
        tempo_d        = tempo_q;
        ocupados_d     = ocupados_q;
        barreira_d     = barreira_q;
        conc_e_d       = 1'b0;
        conc_s_d       = 1'b0;
        ultimo_saida_d = ultimo_saida_q;
        case (estado_q)
            FECHADA: begin
                // On a tie, whichever direction was not served last time wins.
                if (elig_e && (!elig_s || ultimo_saida_q)) begin
                    estado_d       = ABERTA;
                    barreira_d     = 1'b1;
                    conc_e_d       = 1'b1;
                    ultimo_saida_d = 1'b0;
                    ocupados_d     = ocupados_q + 7'd1;
                    tempo_d        = 7'd0;
                    presc_d        = '0;
                end else if (elig_s) begin
                    estado_d       = ABERTA;
                    barreira_d     = 1'b1;
                    conc_s_d       = 1'b1;
                    ultimo_saida_d = 1'b1;
                    ocupados_d     = ocupados_q - 7'd1;
                    tempo_d        = 7'd0;
                    presc_d        = '0;
                end
            end
            ABERTA: begin
                if (bus.sensor_carro) begin
                    tempo_d = 7'd0;
                    presc_d = '0;
                end else begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tempo_d = tempo_inc;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    // Close on the very tick that brings tempo to the limit; tempo keeps that value.
                    if (tempo_d >= TEMPO_AB_7) begin
                        estado_d   = FECHADA;
                        barreira_d = 1'b0;
                    end
                end
            end
            default: begin
                estado_d   = FECHADA;
                barreira_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q       <= FECHADA;
            presc_q        <= '0;
            tempo_q        <= 7'd0;
            ocupados_q     <= 7'd0;
            barreira_q     <= 1'b0;
            conc_e_q       <= 1'b0;
            conc_s_q       <= 1'b0;
            ultimo_saida_q <= 1'b1;
        end else begin
            estado_q       <= estado_d;
            presc_q        <= presc_d;
            tempo_q        <= tempo_d;
            ocupados_q     <= ocupados_d;
            barreira_q     <= barreira_d;
            conc_e_q       <= conc_e_d;
            conc_s_q       <= conc_s_d;
            ultimo_saida_q <= ultimo_saida_d;
        end
    end

    assign bus.barreira        = barreira_q;
    assign bus.concede_entrada = conc_e_q;
    assign bus.concede_saida   = conc_s_q;
    assign bus.tempo           = tempo_q;
    assign bus.ocupados        = ocupados_q;
    assign bus.cheio           = (ocupados_q == LUGARES_7);

`ifdef BARREIRA_AVISO_EN
    localparam int LIMIAR = (TEMPO_ABERTA > 2) ? TEMPO_ABERTA - 2 : 0;

    logic aviso_q, aviso_d, tick;

    // Lamp blinks once per second in the last seconds before closing; dark otherwise.
    always_comb begin
        tick    = (estado_q == ABERTA) && !bus.sensor_carro && (presc_q == PRESC_MAX);
        aviso_d = 1'b0;
        if ((estado_q == ABERTA) && !bus.sensor_carro && (estado_d == ABERTA)) begin
            if (!tick) begin
                aviso_d = aviso_q;
            end else if (int'(tempo_d) >= LIMIAR) begin
                aviso_d = (int'(tempo_q) < LIMIAR) ? 1'b1 : ~aviso_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aviso_q <= 1'b0;
        end else begin
            aviso_q <= aviso_d;
        end
    end

    assign bus.aviso = aviso_q;
`else
    assign bus.aviso = 1'b0;
`endif
endmodule

// File: tb/tb_controlo_barreira.sv
// Directed bench for controlo_barreira with CICLOS_SEG=4, TEMPO_ABERTA=3, LUGARES=2.
module tb_controlo_barreira;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_testes = 0;
    int   n_falhas = 0;

`ifdef BARREIRA_AVISO_EN
    localparam bit AVISO_ON = 1'b1;
`else
    localparam bit AVISO_ON = 1'b0;
`endif

    controlo_barreira_if bus();

    controlo_barreira #(
        .CICLOS_SEG   (4),
        .TEMPO_ABERTA (3),
        .LUGARES      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic passo(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Steps until the barrier reads closed, bounded; returns edges taken.
    task automatic espera_fecho(output int ciclos);
        ciclos = 0;
        while (bus.barreira !== 1'b0 && ciclos < 40) begin
            passo(1);
            ciclos++;
        end
    endtask

    task automatic test_reset();
        bus.pedido_entrada = 1'b0;
        bus.pedido_saida   = 1'b0;
        bus.sensor_carro   = 1'b0;
        reset = 1'b1;
        passo(2);
        n_testes++; if (bus.barreira !== 1'b0) begin n_falhas++; $display("FAIL reset_barreira got %b want 0", bus.barreira); end
        n_testes++; if (bus.concede_entrada !== 1'b0 || bus.concede_saida !== 1'b0) begin n_falhas++; $display("FAIL reset_concede got %b%b want 00", bus.concede_entrada, bus.concede_saida); end
        n_testes++; if (bus.tempo !== 7'd0) begin n_falhas++; $display("FAIL reset_tempo got %0d want 0", bus.tempo); end
        n_testes++; if (bus.ocupados !== 7'd0) begin n_falhas++; $display("FAIL reset_ocupados got %0d want 0", bus.ocupados); end
        n_testes++; if (bus.cheio !== 1'b0 || bus.aviso !== 1'b0) begin n_falhas++; $display("FAIL reset_cheio_aviso got %b%b want 00", bus.cheio, bus.aviso); end
        reset = 1'b0;
        passo(1);
        n_testes++; if (bus.barreira !== 1'b0) begin n_falhas++; $display("FAIL reset_idle_barreira got %b want 0", bus.barreira); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_entrada();
        logic [6:0] exp_t;
        logic       exp_b, exp_a;
        bus.pedido_entrada = 1'b1;
        passo(1);
        bus.pedido_entrada = 1'b0;
        n_testes++; if (bus.barreira !== 1'b1) begin n_falhas++; $display("FAIL entrada_barreira got %b want 1", bus.barreira); end
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.concede_saida !== 1'b0) begin n_falhas++; $display("FAIL entrada_concede got %b%b want 10", bus.concede_entrada, bus.concede_saida); end
        n_testes++; if (bus.ocupados !== 7'd1 || bus.tempo !== 7'd0) begin n_falhas++; $display("FAIL entrada_ocup_tempo got %0d/%0d want 1/0", bus.ocupados, bus.tempo); end
        for (int k = 1; k <= 12; k++) begin
            passo(1);
            exp_t = 7'(k / 4);
            exp_b = (k < 12);
            exp_a = AVISO_ON && (k >= 4) && (k < 8);
            n_testes++; if (bus.tempo !== exp_t) begin n_falhas++; $display("FAIL entrada_tempo[%0d] got %0d want %0d", k, bus.tempo, exp_t); end
            n_testes++; if (bus.barreira !== exp_b) begin n_falhas++; $display("FAIL entrada_barreira[%0d] got %b want %b", k, bus.barreira, exp_b); end
            n_testes++; if (bus.concede_entrada !== 1'b0) begin n_falhas++; $display("FAIL entrada_pulso[%0d] got %b want 0", k, bus.concede_entrada); end
            n_testes++; if (bus.aviso !== exp_a) begin n_falhas++; $display("FAIL entrada_aviso[%0d] got %b want %b", k, bus.aviso, exp_a); end
        end
        passo(1);
        n_testes++; if (bus.barreira !== 1'b0 || bus.tempo !== 7'd3) begin n_falhas++; $display("FAIL entrada_fechada got b=%b t=%0d want b=0 t=3", bus.barreira, bus.tempo); end
        $display("[TB] test_entrada done");
    endtask

    task automatic test_alternancia();
        int c;
        // ocupados=1, last grant was entry: tie goes to exit
        bus.pedido_entrada = 1'b1;
        bus.pedido_saida   = 1'b1;
        passo(1);
        n_testes++; if (bus.concede_saida !== 1'b1 || bus.concede_entrada !== 1'b0 || bus.ocupados !== 7'd0) begin n_falhas++; $display("FAIL alt_saida got s=%b e=%b o=%0d want 1 0 0", bus.concede_saida, bus.concede_entrada, bus.ocupados); end
        espera_fecho(c);
        n_testes++; if (c !== 12) begin n_falhas++; $display("FAIL alt_fecho1 got %0d want 12", c); end
        passo(1);
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.ocupados !== 7'd1) begin n_falhas++; $display("FAIL alt_entrada got e=%b o=%0d want 1 1", bus.concede_entrada, bus.ocupados); end
        espera_fecho(c);
        n_testes++; if (c !== 12) begin n_falhas++; $display("FAIL alt_fecho2 got %0d want 12", c); end
        passo(1);
        n_testes++; if (bus.concede_saida !== 1'b1 || bus.ocupados !== 7'd0) begin n_falhas++; $display("FAIL alt_saida2 got s=%b o=%0d want 1 0", bus.concede_saida, bus.ocupados); end
        bus.pedido_saida = 1'b0;
        espera_fecho(c);
        passo(1);
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.ocupados !== 7'd1) begin n_falhas++; $display("FAIL alt_enche1 got e=%b o=%0d want 1 1", bus.concede_entrada, bus.ocupados); end
        espera_fecho(c);
        passo(1);
        bus.pedido_entrada = 1'b0;
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.ocupados !== 7'd2) begin n_falhas++; $display("FAIL alt_enche2 got e=%b o=%0d want 1 2", bus.concede_entrada, bus.ocupados); end
        espera_fecho(c);
        n_testes++; if (c !== 12) begin n_falhas++; $display("FAIL alt_fecho3 got %0d want 12", c); end
        $display("[TB] test_alternancia done");
    endtask

    task automatic test_cheio();
        int c;
        bus.pedido_entrada = 1'b1;
        for (int k = 0; k < 5; k++) begin
            passo(1);
            n_testes++; if (bus.cheio !== 1'b1 || bus.barreira !== 1'b0 || bus.concede_entrada !== 1'b0) begin n_falhas++; $display("FAIL cheio[%0d] got c=%b b=%b e=%b want 1 0 0", k, bus.cheio, bus.barreira, bus.concede_entrada); end
        end
        bus.pedido_saida = 1'b1;
        passo(1);
        n_testes++; if (bus.concede_saida !== 1'b1 || bus.ocupados !== 7'd1 || bus.cheio !== 1'b0) begin n_falhas++; $display("FAIL cheio_saida got s=%b o=%0d c=%b want 1 1 0", bus.concede_saida, bus.ocupados, bus.cheio); end
        espera_fecho(c);
        passo(1);
        // last grant was exit: tie goes to entry
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.concede_saida !== 1'b0 || bus.ocupados !== 7'd2) begin n_falhas++; $display("FAIL cheio_empate got e=%b s=%b o=%0d want 1 0 2", bus.concede_entrada, bus.concede_saida, bus.ocupados); end
        espera_fecho(c);
        passo(1);
        n_testes++; if (bus.concede_saida !== 1'b1 || bus.ocupados !== 7'd1) begin n_falhas++; $display("FAIL cheio_saida2 got s=%b o=%0d want 1 1", bus.concede_saida, bus.ocupados); end
        bus.pedido_entrada = 1'b0;
        bus.pedido_saida   = 1'b0;
        espera_fecho(c);
        n_testes++; if (c !== 12) begin n_falhas++; $display("FAIL cheio_fecho got %0d want 12", c); end
        $display("[TB] test_cheio done");
    endtask

    task automatic test_sensor();
        int c;
        bus.pedido_entrada = 1'b1;
        passo(1);
        bus.pedido_entrada = 1'b0;
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.ocupados !== 7'd2) begin n_falhas++; $display("FAIL sensor_grant got e=%b o=%0d want 1 2", bus.concede_entrada, bus.ocupados); end
        passo(8);
        n_testes++; if (bus.tempo !== 7'd2) begin n_falhas++; $display("FAIL sensor_pre got %0d want 2", bus.tempo); end
        bus.sensor_carro = 1'b1;
        for (int k = 0; k < 10; k++) begin
            passo(1);
            n_testes++; if (bus.tempo !== 7'd0 || bus.barreira !== 1'b1 || bus.aviso !== 1'b0) begin n_falhas++; $display("FAIL sensor_hold[%0d] got t=%0d b=%b a=%b want 0 1 0", k, bus.tempo, bus.barreira, bus.aviso); end
        end
        bus.sensor_carro = 1'b0;
        espera_fecho(c);
        n_testes++; if (c !== 12) begin n_falhas++; $display("FAIL sensor_fecho got %0d want 12", c); end
        n_testes++; if (bus.tempo !== 7'd3) begin n_falhas++; $display("FAIL sensor_tempo got %0d want 3", bus.tempo); end
        $display("[TB] test_sensor done");
    endtask

    task automatic test_saida_vazio();
        reset = 1'b1;
        passo(1);
        reset = 1'b0;
        bus.pedido_saida = 1'b1;
        for (int k = 0; k < 5; k++) begin
            passo(1);
            n_testes++; if (bus.concede_saida !== 1'b0 || bus.barreira !== 1'b0 || bus.ocupados !== 7'd0) begin n_falhas++; $display("FAIL vazio[%0d] got s=%b b=%b o=%0d want 0 0 0", k, bus.concede_saida, bus.barreira, bus.ocupados); end
        end
        bus.pedido_saida = 1'b0;
        $display("[TB] test_saida_vazio done");
    endtask

    task automatic test_reset_meio();
        bus.pedido_entrada = 1'b1;
        passo(1);
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.ocupados !== 7'd1) begin n_falhas++; $display("FAIL rmeio_grant got e=%b o=%0d want 1 1", bus.concede_entrada, bus.ocupados); end
        passo(4);
        n_testes++; if (bus.tempo !== 7'd1 || bus.barreira !== 1'b1) begin n_falhas++; $display("FAIL rmeio_pre got t=%0d b=%b want 1 1", bus.tempo, bus.barreira); end
        reset = 1'b1;
        passo(1);
        n_testes++; if (bus.barreira !== 1'b0 || bus.tempo !== 7'd0 || bus.ocupados !== 7'd0) begin n_falhas++; $display("FAIL rmeio_reset got b=%b t=%0d o=%0d want 0 0 0", bus.barreira, bus.tempo, bus.ocupados); end
        passo(1);
        n_testes++; if (bus.concede_entrada !== 1'b0 || bus.barreira !== 1'b0) begin n_falhas++; $display("FAIL rmeio_semgrant got e=%b b=%b want 0 0", bus.concede_entrada, bus.barreira); end
        reset = 1'b0;
        passo(1);
        bus.pedido_entrada = 1'b0;
        n_testes++; if (bus.concede_entrada !== 1'b1 || bus.barreira !== 1'b1 || bus.ocupados !== 7'd1) begin n_falhas++; $display("FAIL rmeio_apos got e=%b b=%b o=%0d want 1 1 1", bus.concede_entrada, bus.barreira, bus.ocupados); end
        $display("[TB] test_reset_meio done");
    endtask

    initial begin
        bus.pedido_entrada = 1'b0;
        bus.pedido_saida   = 1'b0;
        bus.sensor_carro   = 1'b0;
        test_reset();
        test_entrada();
        test_alternancia();
        test_cheio();
        test_sensor();
        test_saida_vazio();
        test_reset_meio();
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1, "watchdog");
    end
endmodule
